// File: rtl/rps_match_scorer_if.sv
// Round-result handshake and score/status bundle between the round judge,
// the match scorer and the display stage.
interface rps_match_scorer_if #(
  parameter int CNT_W = 4
);
  logic             round_valid;
  logic [1:0]       round_result;
  logic             round_ready;
  logic             new_match;
  logic [CNT_W-1:0] p1_score;
  logic [CNT_W-1:0] p2_score;
  logic [CNT_W-1:0] tie_count;
  logic [CNT_W-1:0] invalid_count;
  logic             match_over;
  logic [1:0]       match_winner;
  logic [7:0]       status_code;
  logic [CNT_W-1:0] best_streak;
  logic [1:0]       streak_owner;

  modport master (
    output round_valid, round_result, new_match,
    input  round_ready, p1_score, p2_score, tie_count, invalid_count,
           match_over, match_winner, status_code, best_streak, streak_owner
  );

  modport slave (
    input  round_valid, round_result, new_match,
    output round_ready, p1_score, p2_score, tie_count, invalid_count,
           match_over, match_winner, status_code, best_streak, streak_owner
  );
endinterface

// File: rtl/rps_match_scorer.sv
// First-to-WINS_TO_MATCH stone-paper-scissors match scorer with registered status.
// Define RPS_SCORER_STREAK_EN to build the longest-win-streak tracker.
module rps_match_scorer #(
  parameter int WINS_TO_MATCH = 3,
  parameter int CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rps_match_scorer_if.slave    bus
);
  typedef enum logic {PLAY = 1'b0, DONE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] WINS    = CNT_W'(WINS_TO_MATCH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] p1_reg, p1_next, p2_reg, p2_next;
  logic [CNT_W-1:0] tie_reg, tie_next, inv_reg, inv_next;
  logic             over_reg, over_next;
  logic [1:0]       winner_reg, winner_next;
  logic [7:0]       status_reg, status_next;
  logic             accept;

  assign bus.round_ready = (state_reg == PLAY) && !bus.new_match;
  assign accept          = bus.round_valid && bus.round_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= PLAY;
      p1_reg     <= '0;
      p2_reg     <= '0;
      tie_reg    <= '0;
      inv_reg    <= '0;
      over_reg   <= 1'b0;
      winner_reg <= 2'b00;
      status_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      p1_reg     <= p1_next;
      p2_reg     <= p2_next;
      tie_reg    <= tie_next;
      inv_reg    <= inv_next;
      over_reg   <= over_next;
      winner_reg <= winner_next;
      status_reg <= status_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    p1_next     = p1_reg;
    p2_next     = p2_reg;
    tie_next    = tie_reg;
    inv_next    = inv_reg;
    over_next   = over_reg;
    winner_next = winner_reg;
    status_next = status_reg;
    if (bus.new_match) begin
      state_next  = PLAY;
      p1_next     = '0;
      p2_next     = '0;
      tie_next    = '0;
      inv_next    = '0;
      over_next   = 1'b0;
      winner_next = 2'b00;
      status_next = 8'd0;
    end else if (accept) begin
      case (bus.round_result)
        2'b01: begin
          p1_next     = p1_reg + ONE;
          status_next = 8'd49;
          if (p1_next == WINS) begin
            state_next  = DONE;
            over_next   = 1'b1;
            winner_next = 2'b01;
            status_next = 8'h81;
          end
        end
        2'b10: begin
          p2_next     = p2_reg + ONE;
          status_next = 8'd50;
          if (p2_next == WINS) begin
            state_next  = DONE;
            over_next   = 1'b1;
            winner_next = 2'b10;
            status_next = 8'h82;
          end
        end
        2'b00: begin
          if (tie_reg != CNT_MAX) tie_next = tie_reg + ONE;
          status_next = 8'd0;
        end
        default: begin
          if (inv_reg != CNT_MAX) inv_next = inv_reg + ONE;
          status_next = 8'd63;
        end
      endcase
    end
  end

  assign bus.p1_score      = p1_reg;
  assign bus.p2_score      = p2_reg;
  assign bus.tie_count     = tie_reg;
  assign bus.invalid_count = inv_reg;
  assign bus.match_over    = over_reg;
  assign bus.match_winner  = winner_reg;
  assign bus.status_code   = status_reg;

`ifdef RPS_SCORER_STREAK_EN
  // Current run never exceeds WINS_TO_MATCH, so it cannot overflow CNT_W.
  logic [CNT_W-1:0] cur_reg, cur_next, best_reg, best_next;
  logic [1:0]       cur_own_reg, cur_own_next, own_reg, own_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_reg     <= '0;
      cur_own_reg <= 2'b00;
      best_reg    <= '0;
      own_reg     <= 2'b00;
    end else begin
      cur_reg     <= cur_next;
      cur_own_reg <= cur_own_next;
      best_reg    <= best_next;
      own_reg     <= own_next;
    end
  end

  always_comb begin
    cur_next     = cur_reg;
    cur_own_next = cur_own_reg;
    best_next    = best_reg;
    own_next     = own_reg;
    if (bus.new_match) begin
      cur_next     = '0;
      cur_own_next = 2'b00;
      best_next    = '0;
      own_next     = 2'b00;
    end else if (accept && (bus.round_result == 2'b01 || bus.round_result == 2'b10)) begin
      cur_next     = (cur_own_reg == bus.round_result) ? cur_reg + ONE : ONE;
      cur_own_next = bus.round_result;
      if (cur_next > best_reg) begin
        best_next = cur_next;
        own_next  = bus.round_result;
      end
    end
  end

  assign bus.best_streak  = best_reg;
  assign bus.streak_owner = own_reg;
`else
  assign bus.best_streak  = '0;
  assign bus.streak_owner = 2'b00;
`endif
endmodule

// File: tb/tb_rps_match_scorer.sv
// Scoreboard bench for rps_match_scorer: a history-based match model pushes
// expected snapshots, a monitor compares them after each state-changing edge.
module tb_rps_match_scorer;
  localparam int WINS  = 3;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct {
    int p1, p2, tie, inv, over, winner, status, best, owner;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rps_match_scorer_if #(.CNT_W(CNT_W)) bus ();

  rps_match_scorer #(.WINS_TO_MATCH(WINS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  snap_t exp_q[$];
  bit    mon_en   = 1'b0;

  // Reference model: match described as counts plus the ordered list of round wins.
  int m_p1, m_p2, m_tie, m_inv, m_winner, m_last;
  bit m_play;
  int m_wins[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    m_p1 = 0; m_p2 = 0; m_tie = 0; m_inv = 0; m_winner = 0;
    m_last = -1; m_play = 1'b1;
    m_wins.delete();
  endtask

  task automatic model_round(input int code);
    m_last = code;
    case (code)
      1: begin m_p1++; m_wins.push_back(1); if (m_p1 == WINS) begin m_winner = 1; m_play = 1'b0; end end
      2: begin m_p2++; m_wins.push_back(2); if (m_p2 == WINS) begin m_winner = 2; m_play = 1'b0; end end
      0: m_tie = (m_tie < MAXC) ? m_tie + 1 : MAXC;
      default: m_inv = (m_inv < MAXC) ? m_inv + 1 : MAXC;
    endcase
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    int run, prev, best, own;
    s.p1 = m_p1; s.p2 = m_p2; s.tie = m_tie; s.inv = m_inv;
    s.over = m_play ? 0 : 1;
    s.winner = m_winner;
    if (!m_play)           s.status = (m_winner == 1) ? 'h81 : 'h82;
    else if (m_last == 1)  s.status = 49;
    else if (m_last == 2)  s.status = 50;
    else if (m_last == 3)  s.status = 63;
    else                   s.status = 0;
    run = 0; prev = 0; best = 0; own = 0;
    foreach (m_wins[i]) begin
      run  = (m_wins[i] == prev) ? run + 1 : 1;
      prev = m_wins[i];
      if (run > best) begin best = run; own = prev; end
    end
`ifdef RPS_SCORER_STREAK_EN
    s.best = best; s.owner = own;
`else
    s.best = 0; s.owner = 0;
`endif
    return s;
  endfunction

  // One clock cycle of stimulus; pushes an expectation for every state-changing edge.
  task automatic do_cycle(input bit r, input bit nm, input bit v, input int code);
    @(negedge clk);
    rst              = r;
    bus.new_match    = nm;
    bus.round_valid  = v;
    bus.round_result = code[1:0];
    #1;
    if (!r) check("round_ready", int'(bus.round_ready), (m_play && !nm) ? 1 : 0);
    if (r) begin
      model_clear(); exp_q.push_back(model_snap());
    end else if (nm) begin
      model_clear(); exp_q.push_back(model_snap());
    end else if (v && m_play) begin
      model_round(code); exp_q.push_back(model_snap());
    end
    mon_en = 1'b1;
  endtask

  task automatic rounds(input int codes[$]);
    foreach (codes[i]) do_cycle(1'b0, 1'b0, 1'b1, codes[i]);
  endtask

  // Monitor: any edge with reset, new_match or a handshake must match the next expectation.
  initial begin
    snap_t e;
    bit evt;
    forever begin
      @(posedge clk);
      evt = mon_en && (rst || bus.new_match || (bus.round_valid && bus.round_ready));
      if (evt) begin
        #1;
        if (exp_q.size() == 0) begin
          check("unexpected_update", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("p1_score",      int'(bus.p1_score),      e.p1);
          check("p2_score",      int'(bus.p2_score),      e.p2);
          check("tie_count",     int'(bus.tie_count),     e.tie);
          check("invalid_count", int'(bus.invalid_count), e.inv);
          check("match_over",    int'(bus.match_over),    e.over);
          check("match_winner",  int'(bus.match_winner),  e.winner);
          check("status_code",   int'(bus.status_code),   e.status);
          check("best_streak",   int'(bus.best_streak),   e.best);
          check("streak_owner",  int'(bus.streak_owner),  e.owner);
          $display("txn t=%0t p1=%0d p2=%0d tie=%0d inv=%0d over=%0d win=%0d status=%0d best=%0d owner=%0d",
                   $time, bus.p1_score, bus.p2_score, bus.tie_count, bus.invalid_count,
                   bus.match_over, bus.match_winner, bus.status_code, bus.best_streak, bus.streak_owner);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.new_match    = 1'b0;
    bus.round_valid  = 1'b0;
    bus.round_result = 2'b00;
    model_clear();

    do_cycle(1'b1, 1'b0, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 1'b0, 0);
    // P1 sweeps the match, then DONE refuses rounds.
    rounds('{1, 1, 1});
    repeat (5) do_cycle(1'b0, 1'b0, 1'b1, 1);
    do_cycle(1'b0, 1'b1, 1'b0, 0);
    rounds('{1, 2, 0, 3, 2, 2, 2});
    do_cycle(1'b0, 1'b1, 1'b0, 0);
    // Reset mid-match with a round presented.
    rounds('{1, 1, 2});
    do_cycle(1'b1, 1'b0, 1'b1, 1);
    // new_match with a round presented, then tie saturation.
    rounds('{1});
    do_cycle(1'b0, 1'b1, 1'b1, 1);
    repeat (17) do_cycle(1'b0, 1'b0, 1'b1, 0);
    do_cycle(1'b0, 1'b1, 1'b0, 0);
    rounds('{1, 1, 0, 2, 2, 2});
    do_cycle(1'b0, 1'b1, 1'b0, 0);
    repeat (20) do_cycle(1'b0, 1'b0, 1'b1, 3);
    do_cycle(1'b0, 1'b1, 1'b0, 0);
    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      do_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 5),
               ($urandom_range(0, 99) < 70), int'($urandom_range(0, 3)));
    end
    do_cycle(1'b0, 1'b0, 1'b0, 0);
    do_cycle(1'b0, 1'b0, 1'b0, 0);
    check("queue_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rps_match_scorer.md
# rps_match_scorer

Downstream consumer of the stone-paper-scissors round judge. It accepts one judged round result per valid/ready handshake and keeps the running per-player scores, tie count and invalid count. It ends a first-to-`WINS_TO_MATCH` match and drives a registered status code for the display stage. It holds the final result until the next match is explicitly started.

## Interface
- `WINS_TO_MATCH`, default 3: round wins needed to take the match; range 1..2^`CNT_W`-1.
- `CNT_W`, default 4: width of every score/count output.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `round_valid` input 1: `round_result` is presented this cycle.
- `round_result` input 2: 00 tie, 01 P1 wins round, 10 P2 wins round, 11 invalid.
- `round_ready` output 1: scorer accepts a round this cycle.
- `new_match` input 1: one-cycle request to clear scores and start a new match.
- `p1_score` output `CNT_W`: P1 rounds won this match.
- `p2_score` output `CNT_W`: P2 rounds won this match.
- `tie_count` output `CNT_W`: tied rounds this match.
- `invalid_count` output `CNT_W`: invalid rounds this match.
- `match_over` output 1: match decided; scorer is in DONE.
- `match_winner` output 2: 00 none, 01 P1, 10 P2.
- `status_code` output 8: display byte.
- `best_streak` output `CNT_W`: longest run of round wins by one player this match.
- `streak_owner` output 2: 01 P1, 10 P2, 00 none.

## Operation
- FSM has two states.
  - PLAY: the reset state.
  - DONE.
- Handshake:
  - A round is accepted when `round_valid && round_ready` at a rising edge.
  - `round_ready` = (state == PLAY) && !`new_match`. It is combinational and carries no dependency on `round_valid`.
- Accepted round, by code:
  - 01: `p1_score` += 1.
  - 10: `p2_score` += 1.
  - 00: `tie_count` += 1.
  - 11: `invalid_count` += 1.
- Saturation:
  - `tie_count` and `invalid_count` saturate at all-ones and never wrap.
  - Player scores cannot exceed `WINS_TO_MATCH`.
- PLAY→DONE happens on the same edge where the accepted win brings a score to `WINS_TO_MATCH`.
  - That edge sets `match_over`=1 and sets `match_winner` to the round winner.
- DONE:
  - Rounds are refused (`round_ready`=0).
  - All counts are frozen.
- DONE/PLAY→PLAY on `new_match`: all counts, streak state, `match_winner` and `match_over` clear.
- `status_code` in PLAY reflects the last accepted round:
  - 0 for a tie, 49 ('1') for a P1 round win, 50 ('2') for a P2 round win, 63 ('?') for invalid.
  - It is 0 before any round is accepted.
- `status_code` in DONE: 8'h81 if P1 took the match, 8'h82 if P2 did.
- Priority: `rst` > `new_match` > round acceptance. A round presented with `new_match` is not accepted because `round_ready` is low.

## Timing
- All outputs except `round_ready` are registered. They update on the edge that accepts the round, so they are visible one cycle after the handshake cycle.
- Throughput is one round per cycle in PLAY.
- `new_match` takes effect on the next edge. `round_ready` is high again in the following cycle.
- Reset value: all counts 0, `match_over` 0, `match_winner` 00, `status_code` 0, `best_streak` 0, `streak_owner` 00, state PLAY.
- `round_ready` during `rst` is don't-care. It is 1 in the first cycle after reset.
- `rst` asserted mid-match discards the match completely on that edge.

## Configuration
- `RPS_SCORER_STREAK_EN` defined:
  - The current streak increments on each win by the same player.
  - A win by the opposite player restarts the current streak at 1.
  - Ties and invalid rounds leave the streak untouched.
  - `best_streak`/`streak_owner` update when the current streak strictly exceeds `best_streak`, on the same edge as the score update.
- `RPS_SCORER_STREAK_EN` undefined:
  - No streak logic is built.
  - `best_streak`=0 and `streak_owner`=00 permanently.

## Test plan
- Reset, then rounds 01,01,01 back-to-back with `round_valid` held: scores P1 1,2,3. `match_over`=1 and `match_winner`=01 one cycle after the third handshake. `status_code`=8'h81. `round_ready`=0.
- Rounds 01,10,00,11,10,10,10: `p1_score`=1, `p2_score`=3, `tie_count`=1, `invalid_count`=1, winner 10. `status_code` sequence 49,50,0,63,50,50,then 8'h82.
- In DONE, present `round_valid`=1 with 01 for 5 cycles: all counts unchanged. Then pulse `new_match`: everything 0 next cycle and `round_ready`=1.
- Mid-match with P1=2, P2=1: drive `rst` for 1 cycle while `round_valid`=1 and code 01. All outputs are at reset values afterward and no round is counted.
- `new_match` and `round_valid` both high in the same cycle: the round is not counted. Present 17 consecutive ties with `CNT_W`=4: `tie_count` saturates at 15.
- With the macro defined, rounds 01,01,00,10,10,10: `best_streak`=3, `streak_owner`=10. With the macro undefined, both streak outputs stay 0.
